// File: rtl/sa_wsdb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sa_wsdb_pkg
//  Description : Shared types and helpers for the weight-stationary,
//                double-buffered systolic array (sequencer state encoding,
//                default operand widths, activation extension helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package sa_wsdb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int DEF_A_W   = 8;
   localparam int DEF_W_W   = 8;
   localparam int DEF_ACC_W = 32;
   localparam int DEF_K_W   = 16;

   // Extension bit prepended to an activation: its MSB for signed tiles,
   // zero for unsigned tiles.
   function automatic logic ext_act(input logic msb, input logic is_signed);
      return msb & is_signed;
   endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_array_wsdb_pe.sv
`default_nettype none
// ============================================================================
//  Module      : pe_wsdb
//  Description : One processing element. Holds a shadow and an active weight,
//                the activation register forwarded to the next column, and
//                a wrapping accumulator.
//  Ports       : clk, rst_n        clock, async active-low reset
//                adv               array advances this cycle
//                clr               tile start: clear accumulator/forward reg
//                swap              tile start: active weight <= shadow weight
//                shadow_we         write w_in into the shadow weight
//                a_signed          activation signedness for this tile
//                w_in, a_in        weight for shadow bank, incoming activation
//                a_out, acc        forwarded activation, accumulator
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_wsdb
   import sa_wsdb_pkg::*;
#(
   parameter int A_W   = DEF_A_W,
   parameter int W_W   = DEF_W_W,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   input  logic             clr,
   input  logic             swap,
   input  logic             shadow_we,
   input  logic             a_signed,
   input  logic [W_W-1:0]   w_in,
   input  logic [A_W-1:0]   a_in,
   output logic [A_W-1:0]   a_out,
   output logic [ACC_W-1:0] acc
);

   localparam int c_P_W = A_W + W_W + 1;

   logic [W_W-1:0]   r_w_shadow;
   logic [W_W-1:0]   r_w_active;
   logic [A_W-1:0]   r_a_fwd;
   logic [ACC_W-1:0] r_acc;

   logic [A_W:0]     w_a_ext;
   logic [c_P_W-1:0] w_a_sx;
   logic [c_P_W-1:0] w_w_sx;
   logic [c_P_W-1:0] w_prod;
   logic [ACC_W-1:0] w_prod_ext;

   // Both operands are sign-extended to the full product width, so a plain
   // multiply yields the exact two's-complement product.
   assign w_a_ext    = {ext_act(a_in[A_W-1], a_signed), a_in};
   assign w_a_sx     = {{W_W{w_a_ext[A_W]}}, w_a_ext};
   assign w_w_sx     = {{(A_W+1){r_w_active[W_W-1]}}, r_w_active};
   assign w_prod     = w_a_sx * w_w_sx;
   assign w_prod_ext = {{(ACC_W-c_P_W){w_prod[c_P_W-1]}}, w_prod};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_w_shadow <= '0;
         r_w_active <= '0;
         r_a_fwd    <= '0;
         r_acc      <= '0;
      end else begin
         if (shadow_we) r_w_shadow <= w_in;
         if (swap)      r_w_active <= r_w_shadow;
         if (clr) begin
            r_a_fwd <= '0;
            r_acc   <= '0;
         end else if (adv) begin
            r_a_fwd <= a_in;
            r_acc   <= r_acc + w_prod_ext;
         end
      end
   end

   assign a_out = r_a_fwd;
   assign acc   = r_acc;

endmodule
`default_nettype wire

// File: rtl/systolic_array_wsdb.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_array_wsdb
//  Description : Weight-stationary systolic array with double-buffered
//                weights, per-row mask, per-tile activation signedness and a
//                built-in tile sequencer (IDLE/COMPUTE/FLUSH/DONE).
//  Ports       : clk, rst_n                      clock, async active-low reset
//                cfg_start/cfg_ready             tile start handshake
//                cfg_k_len/row_mask/a_signed     tile configuration
//                w_valid/w_ready/w_data          weight-row stream (shadow)
//                a_valid/a_ready/a_data          activation beats
//                busy, shadow_full, done         status
//                c_valid, c_out_flat             finished tile results
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_array_wsdb
   import sa_wsdb_pkg::*;
#(
   parameter int N_ROWS = 14,
   parameter int N_COLS = 14,
   parameter int A_W    = DEF_A_W,
   parameter int W_W    = DEF_W_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int K_W    = DEF_K_W
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cfg_start,
   output logic                             cfg_ready,
   input  logic [K_W-1:0]                   cfg_k_len,
   input  logic [N_ROWS-1:0]                cfg_row_mask,
   input  logic                             cfg_a_signed,
   input  logic                             w_valid,
   output logic                             w_ready,
   input  logic [N_COLS*W_W-1:0]            w_data,
   input  logic                             a_valid,
   output logic                             a_ready,
   input  logic [N_ROWS*A_W-1:0]            a_data,
   output logic                             busy,
   output logic                             shadow_full,
   output logic                             done,
   output logic                             c_valid,
   output logic [N_ROWS*N_COLS*ACC_W-1:0]   c_out_flat
);

   localparam int            c_WC_W      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
   localparam int            c_FL_W      = $clog2(N_ROWS + N_COLS);
   localparam logic [c_WC_W-1:0] c_LAST_ROW  = c_WC_W'(N_ROWS - 1);
   localparam logic [c_FL_W-1:0] c_FLUSH_LEN = c_FL_W'(N_ROWS + N_COLS - 2);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_WC_W-1:0]   r_wcnt;
   logic                r_shadow_full;
   logic [K_W-1:0]      r_k_len;
   logic [K_W-1:0]      r_beat_cnt;
   logic [N_ROWS-1:0]   r_row_mask;
   logic                r_a_signed;
   logic [c_FL_W-1:0]   r_flush_cnt;
   logic                r_done;

   logic w_accept, w_beat, w_last_beat, w_adv, w_w_fire, w_enter_done;

   assign cfg_ready   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && r_shadow_full;
   assign w_ready     = !r_shadow_full;
   assign a_ready     = (r_state == ST_COMPUTE);
   assign busy        = (r_state == ST_COMPUTE) || (r_state == ST_FLUSH);
   assign shadow_full = r_shadow_full;
   assign done        = r_done;
   assign c_valid     = (r_state == ST_DONE);

   assign w_accept    = cfg_start & cfg_ready;
   assign w_beat      = a_valid & a_ready;
   assign w_last_beat = w_beat & (r_beat_cnt == (r_k_len - K_W'(1)));
   assign w_adv       = w_beat | (r_state == ST_FLUSH);
   assign w_w_fire    = w_valid & w_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_enter_done = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_accept) begin
               if (cfg_k_len == '0) begin
                  w_state_nxt  = ST_DONE;
                  w_enter_done = 1'b1;
               end else begin
                  w_state_nxt = ST_COMPUTE;
               end
            end
         end
         ST_COMPUTE: begin
            if (w_last_beat) begin
               if (c_FLUSH_LEN == '0) begin
                  w_state_nxt  = ST_DONE;
                  w_enter_done = 1'b1;
               end else begin
                  w_state_nxt = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            if (r_flush_cnt == '0) begin
               w_state_nxt  = ST_DONE;
               w_enter_done = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wcnt        <= '0;
         r_shadow_full <= 1'b0;
         r_k_len       <= '0;
         r_beat_cnt    <= '0;
         r_row_mask    <= '0;
         r_a_signed    <= 1'b0;
         r_flush_cnt   <= '0;
         r_done        <= 1'b0;
      end else begin
         r_done <= w_enter_done;
         // A last-row write needs w_ready (shadow not full) while an accept
         // needs shadow_full, so the two never collide.
         if (w_accept) begin
            r_shadow_full <= 1'b0;
            r_k_len       <= cfg_k_len;
            r_row_mask    <= cfg_row_mask;
            r_a_signed    <= cfg_a_signed;
            r_beat_cnt    <= '0;
         end else begin
            if (w_w_fire && (r_wcnt == c_LAST_ROW)) r_shadow_full <= 1'b1;
            if (w_beat) r_beat_cnt <= r_beat_cnt + K_W'(1);
         end
         if (w_w_fire) r_wcnt <= (r_wcnt == c_LAST_ROW) ? '0 : r_wcnt + c_WC_W'(1);
         if (w_last_beat)
            r_flush_cnt <= c_FLUSH_LEN;
         else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0))
            r_flush_cnt <= r_flush_cnt - c_FL_W'(1);
      end
   end

   // w_a_h[r][c] is the activation entering PE(r,c); column N_COLS is the
   // forward output of the last column, which has no consumer.
   logic [A_W-1:0] w_a_h [N_ROWS][N_COLS+1];

   for (genvar r = 0; r < N_ROWS; r++) begin : g_row
      logic [A_W-1:0] w_entry;
      logic           w_row_we;

      // Masked rows and flush cycles inject zeros at the skew entry.
      assign w_entry  = ((r_state == ST_COMPUTE) && r_row_mask[r]) ? a_data[r*A_W +: A_W] : '0;
      assign w_row_we = w_w_fire & (r_wcnt == c_WC_W'(r));

      if (r == 0) begin : g_direct
         assign w_a_h[r][0] = w_entry;
      end else begin : g_dly
         logic [A_W-1:0] r_dly [r];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < r; i++) r_dly[i] <= '0;
            end else if (w_accept) begin
               for (int i = 0; i < r; i++) r_dly[i] <= '0;
            end else if (w_adv) begin
               r_dly[0] <= w_entry;
               for (int i = 1; i < r; i++) r_dly[i] <= r_dly[i-1];
            end
         end
         assign w_a_h[r][0] = r_dly[r-1];
      end

      for (genvar c = 0; c < N_COLS; c++) begin : g_col
         pe_wsdb #(
            .A_W   (A_W),
            .W_W   (W_W),
            .ACC_W (ACC_W)
         ) u_pe (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (w_adv),
            .clr       (w_accept),
            .swap      (w_accept),
            .shadow_we (w_row_we),
            .a_signed  (r_a_signed),
            .w_in      (w_data[c*W_W +: W_W]),
            .a_in      (w_a_h[r][c]),
            .a_out     (w_a_h[r][c+1]),
            .acc       (c_out_flat[(r*N_COLS+c)*ACC_W +: ACC_W])
         );
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_wsdb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_array_wsdb
//  Description : Directed self-checking bench for systolic_array_wsdb, 4x4
//                array, 8-bit operands, 32-bit accumulators.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_array_wsdb;

   localparam int NR = 4;
   localparam int NC = 4;
   localparam int AW = 8;
   localparam int WW = 8;
   localparam int AC = 32;
   localparam int KW = 16;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  cfg_start;
   logic                  cfg_ready;
   logic [KW-1:0]         cfg_k_len;
   logic [NR-1:0]         cfg_row_mask;
   logic                  cfg_a_signed;
   logic                  w_valid;
   logic                  w_ready;
   logic [NC*WW-1:0]      w_data;
   logic                  a_valid;
   logic                  a_ready;
   logic [NR*AW-1:0]      a_data;
   logic                  busy;
   logic                  shadow_full;
   logic                  done;
   logic                  c_valid;
   logic [NR*NC*AC-1:0]   c_out_flat;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc;
   logic [31:0] exp_acc [NR][NC];
   logic [7:0]  beat_vals [4];

   systolic_array_wsdb #(
      .N_ROWS (NR), .N_COLS (NC), .A_W (AW), .W_W (WW), .ACC_W (AC), .K_W (KW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_start    (cfg_start),
      .cfg_ready    (cfg_ready),
      .cfg_k_len    (cfg_k_len),
      .cfg_row_mask (cfg_row_mask),
      .cfg_a_signed (cfg_a_signed),
      .w_valid      (w_valid),
      .w_ready      (w_ready),
      .w_data       (w_data),
      .a_valid      (a_valid),
      .a_ready      (a_ready),
      .a_data       (a_data),
      .busy         (busy),
      .shadow_full  (shadow_full),
      .done         (done),
      .c_valid      (c_valid),
      .c_out_flat   (c_out_flat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_row(input logic [31:0] row);
      w_valid = 1'b1;
      w_data  = row;
      tick();
      w_valid = 1'b0;
   endtask

   task automatic load_tile(input logic [31:0] row);
      for (int i = 0; i < NR; i++) load_row(row);
   endtask

   task automatic start(input logic [KW-1:0] k, input logic [NR-1:0] mask, input logic sgn);
      cfg_start    = 1'b1;
      cfg_k_len    = k;
      cfg_row_mask = mask;
      cfg_a_signed = sgn;
      tick();
      cfg_start    = 1'b0;
   endtask

   task automatic beat(input logic [31:0] data);
      a_valid = 1'b1;
      a_data  = data;
      tick();
      a_valid = 1'b0;
   endtask

   // Cycles from the current sample point until done is seen, bounded.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic check_tile(input string tag);
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            chk($sformatf("%s_acc[%0d][%0d]", tag, r, c),
                c_out_flat[(r*NC+c)*AC +: AC], exp_acc[r][c]);
   endtask

   initial begin
      rst_n = 1'b0; cfg_start = 1'b0; cfg_k_len = '0; cfg_row_mask = '0;
      cfg_a_signed = 1'b0; w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
      beat_vals[0] = 8'h01; beat_vals[1] = 8'hFE; beat_vals[2] = 8'h03; beat_vals[3] = 8'h05;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // ---- reset state
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_c_valid", c_valid, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_shadow_full", shadow_full, 0);
      chk("rst_w_ready", w_ready, 1);
      chk("rst_c_out", c_out_flat, 0);

      // ---- basic tile: w=2, a=1, k=3 -> 6
      load_tile(32'h02020202);
      chk("b_shadow_full", shadow_full, 1);
      chk("b_w_ready", w_ready, 0);
      chk("b_cfg_ready", cfg_ready, 1);
      start(16'd3, 4'hF, 1'b1);
      chk("b_busy", busy, 1);
      chk("b_shadow_clr", shadow_full, 0);
      chk("b_c_valid_clr", c_valid, 0);
      for (int k = 0; k < 3; k++) beat(32'h01010101);
      wait_done(cyc);
      chk("b_latency", cyc, 7);
      chk("b_c_valid", c_valid, 1);
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) exp_acc[r][c] = 32'd6;
      check_tile("basic");
      tick();
      chk("b_done_pulse", done, 0);

      // ---- signedness: w=-3, a=0xFF
      load_tile(32'hFDFDFDFD);
      chk("b_c_valid_held", c_valid, 1);
      chk("b_acc_held", c_out_flat[31:0], 6);
      start(16'd1, 4'hF, 1'b1);
      beat(32'hFFFFFFFF);
      wait_done(cyc);
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) exp_acc[r][c] = 32'd3;
      check_tile("signed");
      load_tile(32'hFDFDFDFD);
      start(16'd1, 4'hF, 1'b0);
      beat(32'hFFFFFFFF);
      wait_done(cyc);
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) exp_acc[r][c] = 32'hFFFFFD03;
      check_tile("unsigned");

      // ---- double buffer: A has w[r][c]=c+1, a[r]=r+1, k=20; B loads during A
      load_tile(32'h04030201);
      start(16'd20, 4'hF, 1'b1);
      for (int i = 0; i < 20; i++) begin
         a_valid = 1'b1;
         a_data  = 32'h04030201;
         w_valid = (i < 4);
         w_data  = 32'hFFFFFFFF;
         tick();
      end
      a_valid = 1'b0;
      w_valid = 1'b0;
      chk("db_shadow_early", shadow_full, 1);
      chk("db_done_early", done, 0);
      wait_done(cyc);
      chk("db_a_latency", cyc, 7);
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) exp_acc[r][c] = 20*(r+1)*(c+1);
      check_tile("tileA");
      chk("db_cfg_ready", cfg_ready, 1);
      start(16'd2, 4'hF, 1'b0);
      chk("db_b_busy", busy, 1);
      beat(32'h02020202);
      beat(32'h02020202);
      wait_done(cyc);
      chk("db_b_latency", cyc, 7);
      for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) exp_acc[r][c] = 32'hFFFFFFFC;
      check_tile("tileB");

      // ---- stalls + mask 0101: beats 1,-2,3,5 -> sum 7 on rows 0 and 2
      load_tile(32'h04030201);
      start(16'd4, 4'b0101, 1'b1);
      for (int k = 0; k < 4; k++) begin
         beat({4{beat_vals[k]}});
         if (k < 3) begin
            a_data = 32'h55555555;
            tick();
            tick();
         end
      end
      wait_done(cyc);
      chk("m_latency", cyc, 7);
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            exp_acc[r][c] = (r % 2 == 0) ? 7*(c+1) : 0;
      check_tile("mask");

      // ---- start without shadow tile is ignored
      chk("e_cfg_ready_empty", cfg_ready, 0);
      start(16'd5, 4'hF, 1'b1);
      chk("e_ignored_busy", busy, 0);
      chk("e_ignored_c_valid", c_valid, 1);
      chk("e_ignored_acc", c_out_flat[31:0], 7);

      // ---- k_len = 0
      load_tile(32'h01010101);
      start(16'd0, 4'hF, 1'b1);
      chk("k0_done", done, 1);
      chk("k0_c_valid", c_valid, 1);
      chk("k0_c_out", c_out_flat, 0);
      tick();
      chk("k0_done_pulse", done, 0);

      // ---- reset during FLUSH with a full shadow bank
      load_tile(32'h01010101);
      start(16'd1, 4'hF, 1'b1);
      beat(32'h01010101);
      load_tile(32'h01010101);
      chk("r_busy_flush", busy, 1);
      chk("r_shadow_full", shadow_full, 1);
      rst_n = 1'b0;
      #1;
      chk("r_busy", busy, 0);
      chk("r_done", done, 0);
      chk("r_c_valid", c_valid, 0);
      chk("r_shadow_cleared", shadow_full, 0);
      chk("r_cfg_ready", cfg_ready, 0);
      chk("r_a_ready", a_ready, 0);
      chk("r_c_out", c_out_flat, 0);
      tick();
      rst_n = 1'b1;
      start(16'd1, 4'hF, 1'b1);
      chk("r_start_ignored", busy, 0);
      for (int i = 0; i < 3; i++) load_row(32'h01010101);
      chk("r_partial_reload", shadow_full, 0);
      load_row(32'h01010101);
      chk("r_full_reload", shadow_full, 1);
      chk("r_cfg_ready_reload", cfg_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
